// File: rtl/j1708_tx_scheduler_if.sv
// Register-block, TX-buffer and UART signals of the J1708 transmit scheduler.
// master is the scheduler side, slave is the surrounding register/UART side.
interface j1708_tx_scheduler_if;
  logic       enable;
  logic       tx_new;
  logic [7:0] tx_len;
  logic [2:0] tx_prio;
  logic       bus_rx;
  logic [4:0] buf_addr;
  logic [7:0] buf_data;
  logic [7:0] uart_data;
  logic       uart_start;
  logic       uart_busy;
  logic [7:0] uart_echo;
  logic       uart_echo_valid;
  logic       tx_done;
  logic       tx_ok;
  logic       tx_fail;
  logic       collision;

  modport master (
    input  enable, tx_new, tx_len, tx_prio, bus_rx,
    input  buf_data, uart_busy, uart_echo, uart_echo_valid,
    output buf_addr, uart_data, uart_start,
    output tx_done, tx_ok, tx_fail, collision
  );

  modport slave (
    output enable, tx_new, tx_len, tx_prio, bus_rx,
    output buf_data, uart_busy, uart_echo, uart_echo_valid,
    input  buf_addr, uart_data, uart_start,
    input  tx_done, tx_ok, tx_fail, collision
  );
endinterface

// File: rtl/j1708_tx_scheduler.sv
// J1708 transmit sequencer: bus access wait, byte feed, echo check, retry.
// Define J1708_TX_CHECKSUM_EN to append a generated checksum byte.
module j1708_tx_scheduler #(
  parameter int BIT_CYCLES        = 2500,
  parameter int MAX_RETRIES       = 3,
  parameter int MAX_LEN           = 21,
  parameter int ECHO_TIMEOUT_BITS = 12
) (
  input logic clk,
  input logic rst,
  j1708_tx_scheduler_if.master tx_if
);
  localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);
  localparam logic [7:0] TO_BITS = 8'(ECHO_TIMEOUT_BITS);
`ifdef J1708_TX_CHECKSUM_EN
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN - 1);
`else
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_SEND, S_ECHO, S_DONE
  } state_t;

  state_t         state_q;
  logic [BCW-1:0] bit_q, bit_d;
  logic [4:0]     idle_q, idle_d;
  logic [7:0]     len_q;
  logic [2:0]     prio_q;
  logic           bad_q;
  logic [4:0]     idx_q;
  logic [3:0]     retry_q;
  logic [7:0]     to_q;
  logic [7:0]     uart_data_q;
  logic           uart_start_q;
  logic           tx_done_q;
  logic           tx_ok_q;
  logic           tx_fail_q;
  logic           coll_q;

  logic       tick;
  logic [4:0] access;
  logic       access_ok;
  logic       last;
  logic       echo_bad;
  logic [7:0] tx_byte;

  assign tick      = (bit_q == BIT_LAST);
  assign access    = 5'd10 + {1'b0, prio_q, 1'b0};
  assign access_ok = (idle_q >= access) && !tx_if.uart_busy;
  assign echo_bad  = tx_if.uart_echo_valid
                   ? (tx_if.uart_echo != uart_data_q)
                   : (to_q >= TO_BITS);

`ifdef J1708_TX_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       is_cs;
  // The checksum rides at index len, right after the last buffer byte.
  assign is_cs   = ({3'b0, idx_q} == len_q);
  assign last    = is_cs;
  assign tx_byte = is_cs ? (~sum_q + 8'd1) : tx_if.buf_data;
`else
  assign last    = (({3'b0, idx_q} + 8'd1) == len_q);
  assign tx_byte = tx_if.buf_data;
`endif

  always_comb begin
    bit_d  = tick ? '0 : bit_q + BCW'(1);
    idle_d = idle_q;
    if (!tx_if.bus_rx)
      idle_d = '0;
    else if (tick && idle_q != 5'd31)
      idle_d = idle_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q  <= '0;
      idle_q <= '0;
    end else begin
      bit_q  <= bit_d;
      idle_q <= idle_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      prio_q       <= '0;
      bad_q        <= 1'b0;
      idx_q        <= '0;
      retry_q      <= '0;
      to_q         <= '0;
      uart_data_q  <= '0;
      uart_start_q <= 1'b0;
      tx_done_q    <= 1'b1;
      tx_ok_q      <= 1'b0;
      tx_fail_q    <= 1'b0;
      coll_q       <= 1'b0;
`ifdef J1708_TX_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      uart_start_q <= 1'b0;
      tx_ok_q      <= 1'b0;
      tx_fail_q    <= 1'b0;
      coll_q       <= 1'b0;
      // Losing enable mid-message aborts; a byte in the UART drains alone.
      if (state_q != S_IDLE && state_q != S_DONE && !tx_if.enable) begin
        state_q   <= S_DONE;
        tx_fail_q <= 1'b1;
        tx_done_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (tx_if.tx_new && tx_if.enable) begin
              len_q     <= tx_if.tx_len;
              prio_q    <= tx_if.tx_prio;
              bad_q     <= (tx_if.tx_len == 8'd0)
                        || (tx_if.tx_len > LEN_MAX);
              idx_q     <= '0;
              retry_q   <= '0;
              tx_done_q <= 1'b0;
              state_q   <= S_WAIT;
`ifdef J1708_TX_CHECKSUM_EN
              sum_q     <= '0;
`endif
            end
          end
          S_WAIT: begin
            if (bad_q) begin
              tx_fail_q <= 1'b1;
              tx_done_q <= 1'b1;
              state_q   <= S_DONE;
            end else if (access_ok) begin
              state_q <= S_FETCH;
            end
          end
          S_FETCH: state_q <= S_SEND;
          S_SEND: begin
            uart_data_q  <= tx_byte;
            uart_start_q <= 1'b1;
            to_q         <= '0;
            state_q      <= S_ECHO;
`ifdef J1708_TX_CHECKSUM_EN
            if (!is_cs) sum_q <= sum_q + tx_if.buf_data;
`endif
          end
          S_ECHO: begin
            if (tick) to_q <= to_q + 8'd1;
            if (echo_bad) begin
              coll_q <= 1'b1;
              if (retry_q < RETRY_MAX) begin
                retry_q <= retry_q + 4'd1;
                idx_q   <= '0;
                state_q <= S_WAIT;
`ifdef J1708_TX_CHECKSUM_EN
                sum_q   <= '0;
`endif
              end else begin
                tx_fail_q <= 1'b1;
                tx_done_q <= 1'b1;
                state_q   <= S_DONE;
              end
            end else if (tx_if.uart_echo_valid) begin
              if (last) begin
                tx_ok_q   <= 1'b1;
                tx_done_q <= 1'b1;
                state_q   <= S_DONE;
              end else begin
                idx_q   <= idx_q + 5'd1;
                state_q <= S_FETCH;
              end
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_if.buf_addr   = idx_q;
  assign tx_if.uart_data  = uart_data_q;
  assign tx_if.uart_start = uart_start_q;
  assign tx_if.tx_done    = tx_done_q;
  assign tx_if.tx_ok      = tx_ok_q;
  assign tx_if.tx_fail    = tx_fail_q;
  assign tx_if.collision  = coll_q;
endmodule
